// File: rtl/muldiv_stall_controller.sv
// muldiv_stall_controller
// Sequencer for the multi-cycle MULT/MULTU/DIV/DIVU unit and its HI/LO pair.
// It launches the unit from EX, counts the unit latency, and pulses the HI/LO
// write enable when the result is ready. It stalls the front end only when
// the instruction in ID touches HI/LO while a result is still pending.
//
// Handshake note: there is no ready/back-pressure toward EX. A start seen in
// IDLE is always consumed in that same cycle: it launches the unit or, for a
// divide by zero, is dropped with a oDivZero pulse. A start seen in BUSY is
// ignored and flagged on the sticky oProtoErr, because the ID stall
// guarantees a well-formed pipeline never issues one.
//
// Cycle map for an accepted op of latency L:
//   cycle 0      : oMD_Start=1, still IDLE
//   cycles 1..L  : oBusy=1, cnt counts L-1 down to 0
//   cycle L      : cnt==0, oHiLoWrite=1
//   cycle L+1    : IDLE again, a new start may be accepted
// The FSM state is fully visible on oBusy (IDLE=0, BUSY=1).

module muldiv_stall_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEX_MulDivStart,
  input  logic [1:0]  iEX_MulDivOp,
  input  logic        iEX_DivisorZero,
  input  logic        iID_UsesHiLo,
  output logic        oMD_Start,
  output logic [1:0]  oMD_Op,
  output logic        oHiLoWrite,
  output logic        oBusy,
  output logic        oBlockPC,
  output logic        oBlockIFID,
  output logic        oFlushControl,
  output logic        oDivZero,
  output logic        oProtoErr,
  output logic [15:0] oStallCycles
);

  // The counter only has to hold L-1 for the longer of the two latencies.
  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = $clog2(MaxCycles);

  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [CntW-1:0] cnt;

  // Decoded request terms for the current cycle.
  logic isDiv;
  logic divByZero;
  logic acceptStart;
  logic divZeroHit;
  logic lastCycle;
  logic stallReq;

  // Op bit 1 selects the divide family (DIV/DIVU).
  assign isDiv     = iEX_MulDivOp[1];
  assign divByZero = isDiv && iEX_DivisorZero;

  // Launch, divide-by-zero and write decisions. Reset wins over every other
  // input in the same cycle, so all three pulses are masked by iRST; this
  // also makes a reset in the final BUSY cycle abort without a HI/LO write.
  always_comb begin
    acceptStart = 1'b0;
    divZeroHit  = 1'b0;
    lastCycle   = 1'b0;
    if (!iRST) begin
      if (state == IDLE && iEX_MulDivStart) begin
        acceptStart = !divByZero;
        divZeroHit  = divByZero;
      end
      if (state == BUSY && cnt == '0) begin
        lastCycle = 1'b1;
      end
    end
  end

  // Stall the front end only for HI/LO consumers while a result is pending.
  // The launch cycle counts as pending so an MFLO right behind the mul/div
  // cannot slip into EX before the write. During a reset cycle the stall
  // follows the registered state; it drops once the reset has been taken.
  assign stallReq = iID_UsesHiLo && (state == BUSY || acceptStart);

  assign oMD_Start     = acceptStart;
  assign oDivZero      = divZeroHit;
  assign oHiLoWrite    = lastCycle;
  assign oBusy         = (state == BUSY);
  assign oBlockPC      = stallReq;
  assign oBlockIFID    = stallReq;
  assign oFlushControl = stallReq;

  // Sequencer FSM: launch, latency countdown, held op and protocol-error flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      cnt       <= '0;
      oMD_Op    <= 2'b00;
      oProtoErr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acceptStart) begin
            oMD_Op <= iEX_MulDivOp;
            cnt    <= isDiv ? DivLoad : MultLoad;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (iEX_MulDivStart) begin
            oProtoErr <= 1'b1;
          end
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CntOne;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which this block requested a stall.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oStallCycles <= 16'd0;
    end else if (stallReq && oStallCycles != 16'hFFFF) begin
      oStallCycles <= oStallCycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_muldiv_stall_controller.sv
// Bench for muldiv_stall_controller: directed scenarios plus a randomized run,
// checked against a timestamp-based reference model (start cycle / write
// cycle) and a queue of expected HI/LO write cycles.

module tb_muldiv_stall_controller;

  localparam int MULT_L = 4;
  localparam int DIV_L  = 32;

  // ---------------- clock / reset / DUT ----------------
  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        dz = 1'b0;
  logic        uses = 1'b0;

  logic        oMD_Start;
  logic [1:0]  oMD_Op;
  logic        oHiLoWrite;
  logic        oBusy;
  logic        oBlockPC;
  logic        oBlockIFID;
  logic        oFlushControl;
  logic        oDivZero;
  logic        oProtoErr;
  logic [15:0] oStallCycles;

  always #5 iCLK = ~iCLK;

  muldiv_stall_controller #(
    .MULT_CYCLES(MULT_L),
    .DIV_CYCLES (DIV_L)
  ) dut (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .iEX_MulDivStart(start),
    .iEX_MulDivOp   (op),
    .iEX_DivisorZero(dz),
    .iID_UsesHiLo   (uses),
    .oMD_Start      (oMD_Start),
    .oMD_Op         (oMD_Op),
    .oHiLoWrite     (oHiLoWrite),
    .oBusy          (oBusy),
    .oBlockPC       (oBlockPC),
    .oBlockIFID     (oBlockIFID),
    .oFlushControl  (oFlushControl),
    .oDivZero       (oDivZero),
    .oProtoErr      (oProtoErr),
    .oStallCycles   (oStallCycles)
  );

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // An accepted op is remembered as (start cycle, write cycle); busy means
  // the current cycle lies strictly after the start and up to the write.
  int          cyc      = 0;
  int          startCyc = -1;
  int          wrCyc    = -1;
  bit          mProto   = 1'b0;
  int          mStall   = 0;
  logic [1:0]  mOp      = 2'b00;

  // Scoreboard of expected HI/LO write cycles.
  logic [31:0] exp_q[$];

  // Expected / observed snapshot of the current cycle.
  // vec = {start, hilo_write, busy, block_pc, block_ifid, flush, div_zero}
  logic [6:0]  expVec;
  logic [6:0]  gotVec;
  logic [15:0] expStallCnt;
  logic        expProto;
  logic [1:0]  expOp;

  function automatic bit modelBusy();
    return (startCyc >= 0) && (cyc > startCyc) && (cyc <= wrCyc);
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs at the falling edge, computes what the model
  // expects for that cycle, samples the DUT 2 ns later, then advances the
  // model past the next rising edge.
  task automatic step(input logic s, input logic [1:0] o, input logic d,
                      input logic u, input logic r);
    logic inBusy, eStart, eDz, eWr, eStall;
    @(negedge iCLK);
    iRST  = r;
    start = s;
    op    = o;
    dz    = d;
    uses  = u;
    inBusy = modelBusy();
    eStart = !r && !inBusy && s && !(o[1] && d);
    eDz    = !r && !inBusy && s && o[1] && d;
    eWr    = !r && inBusy && (cyc == wrCyc);
    eStall = u && (inBusy || eStart);
    expVec      = {eStart, eWr, inBusy, eStall, eStall, eStall, eDz};
    expStallCnt = 16'(mStall);
    expProto    = mProto;
    expOp       = mOp;
    #2;
    gotVec = {oMD_Start, oHiLoWrite, oBusy, oBlockPC, oBlockIFID, oFlushControl, oDivZero};
    if (r) begin
      startCyc = -1;
      wrCyc    = -1;
      mProto   = 1'b0;
      mStall   = 0;
      mOp      = 2'b00;
      exp_q.delete();
    end else begin
      if (eStall && mStall < 65535) mStall++;
      if (inBusy && s) mProto = 1'b1;
      if (eWr) begin
        startCyc = -1;
        wrCyc    = -1;
      end
      if (eStart) begin
        startCyc = cyc;
        wrCyc    = cyc + (o[1] ? DIV_L : MULT_L);
        mOp      = o;
        exp_q.push_back(32'(wrCyc));
      end
    end
    cyc++;
  endtask

  task automatic idle(input logic u);
    step(1'b0, 2'b00, 1'b0, u, 1'b0);
  endtask

  task automatic doReset();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    doReset();
    idle(1'b1);
    total++;
    if (gotVec !== 7'b0) begin
      bad++; $display("FAIL reset_pulses got=%b exp=%b", gotVec, 7'b0);
    end
    total++;
    if (oStallCycles !== 16'd0 || oProtoErr !== 1'b0 || oMD_Op !== 2'b00) begin
      bad++;
      $display("FAIL reset_regs got stall=%0d proto=%b op=%b exp 0/0/00",
               oStallCycles, oProtoErr, oMD_Op);
    end
  endtask

  task automatic test_mult_nostall();
    int writes = 0;
    doReset();
    for (int k = 0; k < 7; k++) begin
      step(k == 0, 2'b00, 1'b0, 1'b0, 1'b0);
      total++;
      if (gotVec !== expVec) begin
        bad++; $display("FAIL mult_vec k=%0d got=%b exp=%b", k, gotVec, expVec);
      end
      if (oHiLoWrite === 1'b1) begin
        writes++;
        total++;
        if (k != 4) begin
          bad++; $display("FAIL mult_write_cycle got=%0d exp=4", k);
        end
      end
    end
    total++;
    if (writes != 1 || oStallCycles !== 16'd0) begin
      bad++; $display("FAIL mult_summary got writes=%0d stall=%0d exp 1/0", writes, oStallCycles);
    end
  endtask

  task automatic test_div_stall();
    int stalls = 0;
    doReset();
    for (int k = 0; k < 35; k++) begin
      step(k == 0, 2'b10, 1'b0, 1'b1, 1'b0);
      if (oBlockPC === 1'b1) stalls++;
      total++;
      if (gotVec !== expVec) begin
        bad++; $display("FAIL div_vec k=%0d got=%b exp=%b", k, gotVec, expVec);
      end
      if (k == 32) begin
        total++;
        if (oHiLoWrite !== 1'b1) begin
          bad++; $display("FAIL div_write got=%b exp=1", oHiLoWrite);
        end
      end
      if (k == 33) begin
        total++;
        if (oStallCycles !== 16'd33) begin
          bad++; $display("FAIL div_stall_count got=%0d exp=33", oStallCycles);
        end
      end
    end
    total++;
    if (stalls != 33) begin
      bad++; $display("FAIL div_stall_cycles got=%0d exp=33", stalls);
    end
  endtask

  task automatic test_divzero();
    doReset();
    for (int k = 0; k < 5; k++) begin
      step(k == 0, 2'b11, 1'b1, 1'b1, 1'b0);
      total++;
      if (gotVec !== expVec) begin
        bad++; $display("FAIL divzero_vec k=%0d got=%b exp=%b", k, gotVec, expVec);
      end
      if (k == 0) begin
        total++;
        if (oDivZero !== 1'b1 || oMD_Start !== 1'b0) begin
          bad++; $display("FAIL divzero_pulse got dz=%b start=%b exp 1/0", oDivZero, oMD_Start);
        end
      end
    end
    total++;
    if (oStallCycles !== 16'd0 || oMD_Op !== 2'b00) begin
      bad++; $display("FAIL divzero_regs got stall=%0d op=%b exp 0/00", oStallCycles, oMD_Op);
    end
  endtask

  task automatic test_reset_midop();
    int writes = 0;
    doReset();
    for (int k = 0; k < 10; k++) begin
      step(k == 0 || k == 3, (k == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0, k == 2);
      total++;
      if (gotVec !== expVec) begin
        bad++; $display("FAIL rstmid_vec k=%0d got=%b exp=%b", k, gotVec, expVec);
      end
      if (oHiLoWrite === 1'b1) begin
        writes++;
        total++;
        if (k != 7) begin
          bad++; $display("FAIL rstmid_write_cycle got=%0d exp=7", k);
        end
      end
      if (k == 3) begin
        total++;
        if (oBusy !== 1'b0 || oMD_Start !== 1'b1) begin
          bad++; $display("FAIL rstmid_cycle3 got busy=%b start=%b exp 0/1", oBusy, oMD_Start);
        end
      end
    end
    total++;
    if (writes != 1) begin
      bad++; $display("FAIL rstmid_writes got=%0d exp=1", writes);
    end
  endtask

  task automatic test_proto_err();
    doReset();
    for (int k = 0; k < 8; k++) begin
      step(k == 0 || k == 2, (k == 0) ? 2'b00 : 2'b10, 1'b0, 1'b0, 1'b0);
      total++;
      if (gotVec !== expVec || oProtoErr !== expProto) begin
        bad++;
        $display("FAIL proto_vec k=%0d got=%b/%b exp=%b/%b", k, gotVec, oProtoErr, expVec, expProto);
      end
      if (k == 4) begin
        total++;
        if (oHiLoWrite !== 1'b1) begin
          bad++; $display("FAIL proto_first_write got=%b exp=1", oHiLoWrite);
        end
      end
    end
    total++;
    if (oProtoErr !== 1'b1 || oMD_Op !== 2'b00) begin
      bad++; $display("FAIL proto_sticky got proto=%b op=%b exp 1/00", oProtoErr, oMD_Op);
    end
  endtask

  task automatic test_back_to_back();
    int writes = 0;
    doReset();
    for (int k = 0; k < 12; k++) begin
      step(k == 0 || k == 5, (k == 0) ? 2'b00 : 2'b01, 1'b0, 1'b1, 1'b0);
      total++;
      if (gotVec !== expVec) begin
        bad++; $display("FAIL b2b_vec k=%0d got=%b exp=%b", k, gotVec, expVec);
      end
      if (oHiLoWrite === 1'b1) writes++;
      if (k == 5) begin
        total++;
        if (oMD_Start !== 1'b1) begin
          bad++; $display("FAIL b2b_second_start got=%b exp=1", oMD_Start);
        end
      end
    end
    total++;
    if (writes != 2 || oMD_Op !== 2'b01 || oStallCycles !== 16'd10) begin
      bad++;
      $display("FAIL b2b_summary got writes=%0d op=%b stall=%0d exp 2/01/10", writes, oMD_Op, oStallCycles);
    end
  endtask

  task automatic test_random();
    logic [31:0] wantCyc;
    doReset();
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
      total++;
      if (gotVec !== expVec || oStallCycles !== expStallCnt || oProtoErr !== expProto ||
          oMD_Op !== expOp) begin
        bad++;
        $display("FAIL rand_cycle k=%0d got=%b/%0d/%b/%b exp=%b/%0d/%b/%b", k, gotVec,
                 oStallCycles, oProtoErr, oMD_Op, expVec, expStallCnt, expProto, expOp);
      end
      if (oHiLoWrite === 1'b1 && iRST === 1'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_sb_unexpected_write got_cycle=%0d exp=none", cyc - 1);
        end else begin
          wantCyc = exp_q.pop_front();
          if (wantCyc != 32'(cyc - 1)) begin
            bad++; $display("FAIL rand_sb_write_cycle got=%0d exp=%0d", cyc - 1, wantCyc);
          end
        end
      end
    end
  endtask

  task automatic test_saturation();
    doReset();
    for (int k = 0; k < 70000; k++) begin
      step(!modelBusy(), 2'b10, 1'b0, 1'b1, 1'b0);
      if (k == 65534) begin
        total++;
        if (oStallCycles !== 16'd65534) begin
          bad++; $display("FAIL sat_before got=%0d exp=65534", oStallCycles);
        end
      end
      if (k == 65535 || k == 69999) begin
        total++;
        if (oStallCycles !== 16'hFFFF) begin
          bad++; $display("FAIL sat_hold k=%0d got=%h exp=ffff", k, oStallCycles);
        end
      end
    end
    total++;
    if (oProtoErr !== 1'b0 || expStallCnt !== 16'hFFFF) begin
      bad++; $display("FAIL sat_end got proto=%b model=%h exp 0/ffff", oProtoErr, expStallCnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mult_nostall();
    test_div_stall();
    test_divzero();
    test_reset_midop();
    test_proto_err();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_stall_controller.md
# muldiv_stall_controller

Sequencer for the multi-cycle MULT/MULTU/DIV/DIVU unit and its HI/LO registers in the pipelined core. It launches the unit when a mul/div instruction is in EX and counts the unit's latency. It commits the result to HI/LO and stalls the front end only when the instruction in ID touches HI/LO while the unit is busy. Its stall outputs are OR-ed with the hazard-detection stall signals (block PC, block IF/ID, flush control into ID/EX).

## Interface
Parameters:
- MULT_CYCLES, 4, cycles from start to HI/LO write for MULT/MULTU (>= 2)
- DIV_CYCLES, 32, cycles from start to HI/LO write for DIV/DIVU (>= 2)

Ports:
- iCLK  in  1  clock; all state updates on rising edge
- iRST  in  1  synchronous, active-high reset
- iEX_MulDivStart  in  1  mul/div instruction valid in EX this cycle
- iEX_MulDivOp  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- iEX_DivisorZero  in  1  rt operand of the EX instruction is zero
- iID_UsesHiLo  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO or any mul/div
- oMD_Start  out  1  one-cycle launch pulse to the mul/div unit
- oMD_Op  out  2  operation held stable for the unit while busy
- oHiLoWrite  out  1  one-cycle HI/LO write enable (unit result)
- oBusy  out  1  unit computing
- oBlockPC, oBlockIFID, oFlushControl  out  1 each  stall request (all three identical)
- oDivZero  out  1  one-cycle pulse: divide by zero, no HI/LO write
- oProtoErr  out  1  sticky: start received while busy
- oStallCycles  out  16  saturating count of cycles this block stalled

## Operation
- FSM states: IDLE, BUSY. Down-counter cnt, width clog2(max(MULT_CYCLES, DIV_CYCLES)).
- IDLE with iEX_MulDivStart:
  - DIV/DIVU with iEX_DivisorZero: oDivZero=1, oMD_Start=0, remain IDLE. HI/LO are left unchanged.
  - Otherwise: oMD_Start=1 (combinational, same cycle). Register oMD_Op←iEX_MulDivOp. Set cnt←L−1, where L = MULT_CYCLES for ops 00/01 and DIV_CYCLES for ops 10/11. Next state BUSY.
- BUSY:
  - cnt>0: decrement.
  - cnt==0: oHiLoWrite=1 this cycle, next state IDLE.
  - iEX_MulDivStart in BUSY: ignored, oProtoErr set (sticky until reset). A correct pipeline never produces this, because of the ID stall below.
- Stall condition: iID_UsesHiLo && (state==BUSY || oMD_Start). Drives oBlockPC=oBlockIFID=oFlushControl=1, otherwise all 0. Independent instructions flow without stall.
- oBusy = (state==BUSY).
- oStallCycles increments each cycle the stall is asserted and saturates at 16'hFFFF.
- Reset values: state IDLE, cnt 0, oMD_Op 00, oProtoErr 0, oStallCycles 0. All pulse outputs 0 when inputs are idle.
- Reset mid-operation: abort to IDLE with no oHiLoWrite. Stall outputs drop once iRST has been sampled.

## Timing
- Cycle 0 = start accepted (oMD_Start=1). Cycles 1..L = BUSY. oHiLoWrite is asserted in cycle L. Cycle L+1 = IDLE.
- oBusy is high for exactly L cycles.
- An MFLO in ID during cycle 0 stalls for cycles 0..L (L+1 cycles). It advances to EX in cycle L+1 and reads the updated LO.
- A new start may be accepted in cycle L+1. Back-to-back ops therefore have no dead cycle beyond L+1.
- oDivZero, oMD_Start, and oHiLoWrite are never asserted in the same cycle.
- iRST has priority over every other input in the same cycle.

## Test plan
- MULT start at cycle 0, iID_UsesHiLo=0 throughout → oMD_Start high in cycle 0; oBusy high in cycles 1–4; oHiLoWrite high only in cycle 4; stall never asserted; oStallCycles=0.
- DIV start, iID_UsesHiLo=1 from cycle 0 → stall high in cycles 0–32; oHiLoWrite high in cycle 32; oStallCycles=33.
- DIVU with iEX_DivisorZero=1 → oDivZero for one cycle; oMD_Start=0; oHiLoWrite never asserted; oBusy stays 0.
- MULTU, with iRST asserted in cycle 2 → cycle 3 shows IDLE, oBusy=0, no oHiLoWrite; a new MULT in cycle 3 completes normally in cycle 7.
- MULT, then iEX_MulDivStart again in cycle 2 → second start ignored (no oMD_Start); oProtoErr=1 and remains 1; the first op still writes in cycle 4.
- Stall held for 70000 cycles (repeated DIVs with iID_UsesHiLo=1) → oStallCycles saturates at 16'hFFFF and does not wrap.
